// File: rtl/rat_io_pkg.sv
// Shared constants and types for the RAT port-mapped UART transmitter.
// Port addresses, status bit positions and the serial FSM state encoding.
package rat_io_pkg;

  localparam logic [7:0] RAT_DATA_PORT = 8'h40;
  localparam logic [7:0] RAT_STAT_PORT = 8'h41;
  localparam logic [7:0] RAT_CTRL_PORT = 8'h42;

  localparam int STAT_FULL_BIT = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT = 2;
  localparam int STAT_PEND_BIT = 3;
  localparam int STAT_OVF_BIT = 4;

  localparam int CTRL_INT_EN_BIT = 0;
  localparam int CTRL_CLR_PEND_BIT = 1;
  localparam int CTRL_CLR_OVF_BIT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/rat_fifo_sync.sv
// Single-clock FIFO with show-ahead output; push is refused when full and
// pop is refused when empty, so callers may assert them unconditionally.
module rat_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rat_uart_tx.sv
// Port-mapped 8N1 UART transmitter on the RAT MCU output bus, with a status
// byte for the IN_PORT mux and a level interrupt when the transmitter drains.
module rat_uart_tx
  import rat_io_pkg::*;
#(
  parameter int         BAUD_DIV   = 868,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] DATA_PORT  = RAT_DATA_PORT,
  parameter logic [7:0] STAT_PORT  = RAT_STAT_PORT,
  parameter logic [7:0] CTRL_PORT  = RAT_CTRL_PORT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] RD_DATA,
  output logic       RD_SEL,
  output logic       TX,
  output logic       INT_REQ
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  tx_state_t     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic strb_q, strb_d;
  logic int_en_q, int_en_d;
  logic int_pending_q, int_pending_d;
  logic overflow_q, overflow_d;
  logic int_req_q, int_req_d;

  logic       wr, data_wr, ctrl_wr;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic       baud_last, frame_done;
  logic [7:0] status;

  // A held strobe is a single write: only its rising cycle counts.
  assign wr      = IO_STRB & ~strb_q;
  assign data_wr = wr && (PORT_ID == DATA_PORT);
  assign ctrl_wr = wr && (PORT_ID == CTRL_PORT);

  assign baud_last  = (baud_q == BW'(BAUD_DIV - 1));
  assign fifo_push  = data_wr & ~fifo_full;
  assign fifo_pop   = ~fifo_empty &
                      ((state_q == IDLE) || ((state_q == STOP) && baud_last));
  assign frame_done = (state_q == STOP) && baud_last && fifo_empty;

  rat_fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (OUT_PORT),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Set events take priority over write-1-to-clear in the same cycle.
  always_comb begin
    strb_d        = IO_STRB;
    int_en_d      = int_en_q;
    int_pending_d = int_pending_q;
    overflow_d    = overflow_q;
    if (ctrl_wr) begin
      int_en_d = OUT_PORT[CTRL_INT_EN_BIT];
      if (OUT_PORT[CTRL_CLR_PEND_BIT]) int_pending_d = 1'b0;
      if (OUT_PORT[CTRL_CLR_OVF_BIT])  overflow_d    = 1'b0;
    end
    if (frame_done)             int_pending_d = 1'b1;
    if (data_wr && fifo_full)   overflow_d    = 1'b1;
    int_req_d = int_pending_q & int_en_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      strb_q        <= 1'b0;
      int_en_q      <= 1'b0;
      int_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      int_req_q     <= 1'b0;
    end else begin
      strb_q        <= strb_d;
      int_en_q      <= int_en_d;
      int_pending_q <= int_pending_d;
      overflow_q    <= overflow_d;
      int_req_q     <= int_req_d;
    end
  end

  // TX is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (!fifo_empty) state_q <= START;
        end
        START: begin
          tx_q <= 1'b0;
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= fifo_empty ? IDLE : START;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (fifo_pop)                             shift_q <= fifo_dout;
    else if ((state_q == DATA) && baud_last)  shift_q <= {1'b0, shift_q[7:1]};
  end

  always_comb begin
    status                 = 8'h00;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_BUSY_BIT]  = (state_q != IDLE);
    status[STAT_PEND_BIT]  = int_pending_q;
    status[STAT_OVF_BIT]   = overflow_q;
  end

  assign RD_SEL  = (PORT_ID == STAT_PORT);
  assign RD_DATA = RD_SEL ? status : 8'h00;
  assign TX      = tx_q;
  assign INT_REQ = int_req_q;

endmodule

// File: tb/tb_rat_uart_tx.sv
// Bench for rat_uart_tx: a queue/frame-time model checked every cycle, a small
// serial receiver, and directed scenarios with hand-computed expectations.
module tb_rat_uart_tx;

  localparam int B = 4;
  localparam int D = 8;
  localparam logic [7:0] P_DATA = 8'h40;
  localparam logic [7:0] P_STAT = 8'h41;
  localparam logic [7:0] P_CTRL = 8'h42;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] PORT_ID = P_STAT;
  logic [7:0] OUT_PORT = 8'h00;
  logic       IO_STRB = 1'b0;
  logic [7:0] RD_DATA;
  logic       RD_SEL;
  logic       TX;
  logic       INT_REQ;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  rat_uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .RD_DATA(RD_DATA), .RD_SEL(RD_SEL), .TX(TX),
    .INT_REQ(INT_REQ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  bit         m_busy, m_pend, m_ovf, m_en, m_prev, m_tx, m_int;
  int         m_t;
  logic [7:0] m_byte;
  bit         mw, mpop, mend, mset_pend, mset_ovf, nx_tx, nx_int;
  int         msz;
  logic [7:0] mb;

  function automatic bit frame_bit(input logic [7:0] b, input int seg);
    if (seg == 0) return 1'b0;
    if (seg >= 9) return 1'b1;
    return b[seg-1];
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mq.delete();
      m_busy = 0; m_pend = 0; m_ovf = 0; m_en = 0; m_prev = 0;
      m_tx = 1; m_int = 0; m_t = 0;
    end else begin
      nx_tx  = m_busy ? frame_bit(m_byte, m_t / B) : 1'b1;
      nx_int = m_pend & m_en;
      mw = IO_STRB & ~m_prev;
      m_prev = IO_STRB;
      msz = mq.size();
      mend = m_busy && (m_t == 10*B - 1);
      mpop = (msz > 0) && (!m_busy || mend);
      mset_pend = 0; mset_ovf = 0;
      if (mpop) mb = mq.pop_front();
      if (!m_busy) begin
        if (mpop) begin m_busy = 1; m_t = 0; m_byte = mb; end
      end else if (mend) begin
        if (mpop) begin m_t = 0; m_byte = mb; end
        else begin m_busy = 0; mset_pend = 1; end
      end else begin
        m_t++;
      end
      if (mw && PORT_ID == P_DATA) begin
        if (msz == D) mset_ovf = 1;
        else mq.push_back(OUT_PORT);
      end
      if (mw && PORT_ID == P_CTRL) begin
        m_en = OUT_PORT[0];
        if (OUT_PORT[1]) m_pend = 0;
        if (OUT_PORT[2]) m_ovf = 0;
      end
      if (mset_pend) m_pend = 1;
      if (mset_ovf)  m_ovf = 1;
      m_tx = nx_tx;
      m_int = nx_int;
    end
  end

  function automatic logic [7:0] m_status();
    return {3'b000, m_ovf, m_pend, m_busy, mq.size() == 0, mq.size() == D};
  endfunction

  // ---------------- per-cycle compare and serial receiver ----------------
  logic [7:0] rx_q[$];
  bit         rx_busy = 0, rx_prev = 1;
  int         rx_j;
  logic [7:0] rx_sh;

  always @(negedge CLK) begin
    #1;
    if (cmp_en) begin
      chk("tx", {7'b0, TX}, {7'b0, m_tx});
      chk("int_req", {7'b0, INT_REQ}, {7'b0, m_int});
      chk("rd_sel", {7'b0, RD_SEL}, {7'b0, PORT_ID == P_STAT});
      chk("rd_data", RD_DATA, (PORT_ID == P_STAT) ? m_status() : 8'h00);
    end
    if (RESET) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (rx_prev && !TX) begin rx_busy = 1; rx_j = 0; end
    end else begin
      rx_j++;
      if (rx_j >= 6 && rx_j <= 34 && (rx_j % 4) == 2) rx_sh[(rx_j-6)/4] = TX;
      if (rx_j == 38) begin rx_q.push_back(rx_sh); rx_busy = 0; end
    end
    rx_prev = TX;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr_port(input logic [7:0] port, input logic [7:0] data);
    @(negedge CLK);
    PORT_ID = port; OUT_PORT = data; IO_STRB = 1'b1;
    @(negedge CLK);
    IO_STRB = 1'b0; PORT_ID = P_STAT;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
    #2;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    cyc(2);
    for (int i = 0; i < 600 && !done; i++) begin
      if (RD_DATA[2] == 1'b0) done = 1;
      else cyc(1);
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: busy still 1 expected 0 at %0t", $time);
    end
  endtask

  int base;
  logic [7:0] exp_bits [10];

  initial begin
    // 1. reset
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    cmp_en = 1'b1;
    #2;
    chk("reset_tx", {7'b0, TX}, 8'h01);
    chk("reset_int", {7'b0, INT_REQ}, 8'h00);
    chk("reset_rdsel", {7'b0, RD_SEL}, 8'h01);
    chk("reset_stat", RD_DATA, 8'h02);

    // 2. single frame of 8'h55
    wr_port(P_DATA, 8'h55);
    cyc(2);
    chk("t2_start_lat", {7'b0, TX}, 8'h00);
    exp_bits = '{8'h0, 8'h1, 8'h0, 8'h1, 8'h0, 8'h1, 8'h0, 8'h1, 8'h0, 8'h1};
    for (int s = 0; s < 10; s++) begin
      cyc(s == 0 ? 1 : 4);
      chk($sformatf("t2_seg%0d", s), {7'b0, TX}, exp_bits[s]);
      if (s == 4) chk("t2_busy", {7'b0, RD_DATA[2]}, 8'h01);
    end
    cyc(5);
    chk("t2_after", {5'b0, RD_DATA[2:0]}, 8'h02);
    chk("t2_rx", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h55);

    // 3. overflow burst
    wr_port(P_CTRL, 8'h06);
    base = rx_q.size();
    for (int i = 1; i <= 10; i++) wr_port(P_DATA, 8'(i));
    #2;
    chk("t3_full_ovf", RD_DATA, 8'h15);
    wait_idle();
    chk("t3_count", 8'(rx_q.size() - base), 8'd9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("t3_rx%0d", i), (base + i < rx_q.size()) ? rx_q[base+i] : 8'hxx, 8'(i + 1));
    wr_port(P_CTRL, 8'h04);
    #2;
    chk("t3_ovf_clr", {7'b0, RD_DATA[4]}, 8'h00);

    // 4. interrupt
    wr_port(P_CTRL, 8'h03);
    wr_port(P_CTRL, 8'h01);
    wr_port(P_DATA, 8'h3C);
    cyc(10);
    chk("t4_int_during", {7'b0, INT_REQ}, 8'h00);
    wait_idle();
    cyc(1);
    chk("t4_int_set", {7'b0, INT_REQ}, 8'h01);
    chk("t4_pend", {7'b0, RD_DATA[3]}, 8'h01);
    wr_port(P_CTRL, 8'h03);
    #2;
    chk("t4_int_lag", {7'b0, INT_REQ}, 8'h01);
    cyc(1);
    chk("t4_int_clr", {7'b0, INT_REQ}, 8'h00);
    wr_port(P_CTRL, 8'h00);
    wr_port(P_DATA, 8'hC3);
    wait_idle();
    cyc(2);
    chk("t4_int_masked", {7'b0, INT_REQ}, 8'h00);
    chk("t4_pend2", {7'b0, RD_DATA[3]}, 8'h01);

    // 5. held strobe and unmatched port
    base = rx_q.size();
    @(negedge CLK);
    PORT_ID = P_DATA; OUT_PORT = 8'hA5; IO_STRB = 1'b1;
    cyc(3);
    IO_STRB = 1'b0; PORT_ID = P_STAT;
    wait_idle();
    cyc(50);
    chk("t5_one_frame", 8'(rx_q.size() - base), 8'd1);
    chk("t5_byte", rx_q.size() > 0 ? rx_q[rx_q.size()-1] : 8'hxx, 8'hA5);
    base = rx_q.size();
    wr_port(8'h10, 8'h77);
    cyc(60);
    chk("t5_no_frame", 8'(rx_q.size() - base), 8'd0);
    chk("t5_idle", {7'b0, RD_DATA[2]}, 8'h00);
    @(negedge CLK);
    PORT_ID = 8'h10;
    #2;
    chk("t5_rdsel", {7'b0, RD_SEL}, 8'h00);
    chk("t5_rddata", RD_DATA, 8'h00);
    @(negedge CLK);
    PORT_ID = P_STAT;

    // 6. reset mid-frame during data bit 3
    base = rx_q.size();
    wr_port(P_DATA, 8'hF0);
    cyc(2 + 4*4);
    chk("t6_bit3", {7'b0, TX}, 8'h00);
    #1;
    RESET = 1'b1;
    #1;
    chk("t6_tx_reset", {7'b0, TX}, 8'h01);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #2;
    chk("t6_stat", RD_DATA, 8'h02);
    cyc(80);
    chk("t6_no_resume", 8'(rx_q.size() - base), 8'd0);
    chk("t6_idle", RD_DATA, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rat_uart_tx.md
Name: rat_uart_tx

Overview:
Port-mapped UART transmitter that consumes the RAT MCU output bus: PORT_ID, OUT_PORT and IO_STRB. OUT writes to the data port enqueue bytes into a small FIFO. A serial FSM shifts each byte out as 8N1. A status byte is returned on RD_DATA for the top-level IN_PORT mux, and an optional interrupt request drives the MCU INT_CU input when the transmitter drains.

Parameters:
BAUD_DIV, 868, clock cycles per serial bit (100 MHz / 115200); minimum 2
FIFO_DEPTH, 8, FIFO entries; power of 2, minimum 2
DATA_PORT, 8'h40, port ID for OUT of transmit data
STAT_PORT, 8'h41, port ID for IN of status
CTRL_PORT, 8'h42, port ID for OUT of control

Ports:
CLK  in  1  system clock; all state updates on rising edge
RESET  in  1  asynchronous, active-high reset
PORT_ID  in  8  MCU port address
OUT_PORT  in  8  MCU output data
IO_STRB  in  1  MCU I/O write strobe
RD_DATA  out  8  status byte when PORT_ID==STAT_PORT, else 8'h00 (combinational)
RD_SEL  out  1  1 when PORT_ID==STAT_PORT (combinational)
TX  out  1  serial line; idle high
INT_REQ  out  1  interrupt request to MCU INT_CU (level)

Behaviour:
- Reset (async, active-high): TX=1, INT_REQ=0, FIFO empty, FSM=IDLE, CTRL=0, int_pending=0, overflow=0, strobe history=0. Reset mid-frame aborts the frame immediately. No partial byte is retained.
- Write detection: a write occurs on the first cycle IO_STRB=1 after a cycle with IO_STRB=0; a held strobe counts as one write. PORT_ID and OUT_PORT are sampled in that cycle. Writes to unmatched ports are ignored.
- DATA_PORT write: pushes OUT_PORT if the FIFO is not full at that cycle. If full, the byte is dropped and overflow is set (sticky). Fullness is judged before any same-cycle pop, so a pop does not rescue the write.
- CTRL_PORT write:
  - bit0 loads INT_EN.
  - bit1=1 clears int_pending.
  - bit2=1 clears overflow.
  - Bits 1 and 2 are write-1-to-clear and are not stored.
  - When a set event and a clear occur in the same cycle, the set wins.
- Status byte: bit0 full, bit1 empty, bit2 busy (FSM!=IDLE), bit3 int_pending, bit4 overflow, bits7:5 = 0.
- FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..BAUD_DIV-1 and reloads in each state.
  - IDLE: TX=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: TX=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: TX=shift[0] for BAUD_DIV cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: TX=1 for BAUD_DIV cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE and set int_pending.
- Latency: with a write captured at edge k into an empty FIFO and an idle FSM, the FIFO is non-empty after k, the pop happens at k+1, and TX=0 after edge k+2. One frame lasts 10*BAUD_DIV cycles.
- Simultaneous push and pop: both take effect and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. The count is held in log2(FIFO_DEPTH)+1 bits.
- INT_REQ = int_pending & INT_EN, registered. INT_REQ updates one cycle after int_pending or INT_EN changes.

Decomposition:
- Package rat_io_pkg:
  - port address constants
  - status bit index constants
  - typedef enum tx_state_t {IDLE, START, DATA, STOP}
- Sub-module rat_fifo_sync (params WIDTH, DEPTH):
  - inputs: push, pop, din
  - outputs: dout, full, empty
  - async reset on CLK/RESET
- Top level: strobe edge detect, port decode, CTRL/status registers, baud counter, TX FSM.

Test Plan (BAUD_DIV=4, FIFO_DEPTH=8):
1. Assert RESET for 3 cycles, release -> TX=1, INT_REQ=0. With PORT_ID=8'h41: RD_SEL=1, RD_DATA=8'h02.
2. OUT 8'h55 to 8'h40 -> TX=0 two edges after capture, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop=1. Frame is 40 cycles. Status bit2=1 during the frame, 8'h02 after.
3. Ten DATA_PORT writes 8'h01..8'h0A on alternate cycles while idle -> the first byte is popped, status shows full=1 and overflow=1, and TX emits 9 contiguous frames (360 cycles) with 8'h0A missing. CTRL write 8'h04 then clears overflow.
4. CTRL=8'h01, OUT one byte -> INT_REQ=0 during the frame, then 1 after the stop bit ends, with status bit3=1. CTRL write 8'h03 -> INT_REQ=0 one cycle later. Repeat with CTRL=8'h00 -> INT_REQ stays 0 while bit3=1.
5. IO_STRB held high 3 cycles with PORT_ID=8'h40 -> exactly one frame sent. A write to PORT_ID=8'h10 -> no frame. PORT_ID=8'h10 gives RD_SEL=0, RD_DATA=8'h00.
6. Assert RESET in the middle of DATA bit 3 -> TX=1 immediately. Status is 8'h02 after release and no frame resumes.
